// File: rtl/bus_store_pkg.sv
// Shared types for the bus store unit: default widths, queue entry layout and
// the address-capture FSM encoding.
package bus_store_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } store_entry_t;

  typedef enum logic {
    NO_ADDR,
    ADDR_HELD
  } addr_state_t;

endpackage

// File: rtl/bus_store_unit_fifo.sv
// store_fifo: posted-write queue of store entries. With BUS_STORE_FWD_EN defined it
// also exposes an age-ordered view (index 0 = oldest) plus per-slot valid bits.
module store_fifo
  import bus_store_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = store_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_entry,
  output entry_t head,
  output logic   full,
  output logic   empty
`ifdef BUS_STORE_FWD_EN
  ,
  output entry_t [DEPTH-1:0] entries,
  output logic   [DEPTH-1:0] valid
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

`ifdef BUS_STORE_FWD_EN
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PW'(k)];
      valid[k]   = (CW'(k) < count);
    end
  end
`endif

endmodule

// File: rtl/bus_store_unit.sv
// bus_store_unit: captures stores/pushes from the shared bus into a posted-write
// queue drained on RAM grant. Optional store forwarding under BUS_STORE_FWD_EN.
module bus_store_unit
  import bus_store_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus,
  input  logic              addr_ld,
  input  logic              data_ld,
  input  logic              push,
  input  logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_next,
  output logic              sp_upd,
  output logic              ram_req,
  input  logic              ram_grant,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              full,
  output logic              empty,
  output logic              err
`ifdef BUS_STORE_FWD_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bsu_entry_t;

  addr_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sp_dec;
  logic              enq, accept, push_ok, err_d;
  bsu_entry_t        enq_entry, head;

  assign sp_dec   = sp - ADDR_W'(1);
  assign ram_req  = !empty;
  assign ram_wren = ram_req && ram_grant;
  assign ram_addr = empty ? '0 : head.addr;
  assign ram_data = empty ? '0 : head.data;

  assign enq     = data_ld && (push || state_q == ADDR_HELD);
  assign accept  = enq && (!full || ram_wren);
  assign push_ok = accept && push;

  always_comb begin
    enq_entry.addr = push ? sp_dec : addr_q;
    enq_entry.data = bus;
  end

  // data_ld takes priority; a concurrent addr_ld is discarded and flagged.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err;
    if (data_ld && !push) begin
      if (state_q == ADDR_HELD) state_d = NO_ADDR;
      else                      err_d   = 1'b1;
    end else if (addr_ld && !data_ld) begin
      state_d = ADDR_HELD;
      addr_d  = bus;
    end
    if (addr_ld && data_ld) err_d = 1'b1;
    if (enq && !accept)     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NO_ADDR;
      addr_q  <= '0;
      err     <= 1'b0;
      sp_upd  <= 1'b0;
      sp_next <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err     <= err_d;
      sp_upd  <= push_ok;
      if (push_ok) sp_next <= sp_dec;
    end
  end

`ifdef BUS_STORE_FWD_EN
  bsu_entry_t [DEPTH-1:0] q_entries;
  logic       [DEPTH-1:0] q_valid;

  // Scan oldest to newest so the last match (newest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (q_valid[k] && q_entries[k].addr == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = q_entries[k].data;
      end
    end
  end
`endif

  store_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(bsu_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (enq),
    .pop     (ram_wren),
    .wr_entry(enq_entry),
    .head    (head),
    .full    (full),
    .empty   (empty)
`ifdef BUS_STORE_FWD_EN
    ,
    .entries (q_entries),
    .valid   (q_valid)
`endif
  );

endmodule

// File: tb/tb_bus_store_unit.sv
// Randomized scoreboard bench for bus_store_unit against a queue-based reference model.
module tb_bus_store_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, addr_ld, data_ld, push, ram_grant;
  logic [15:0] bus, sp, sp_next, ram_addr, ram_data;
  logic        sp_upd, ram_req, ram_wren, full, empty, err;
`ifdef BUS_STORE_FWD_EN
  logic [15:0] rd_addr, fwd_data;
  logic        fwd_hit;
`endif

  always #5 clk = ~clk;

  bus_store_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .addr_ld(addr_ld), .data_ld(data_ld),
    .push(push), .sp(sp), .sp_next(sp_next), .sp_upd(sp_upd), .ram_req(ram_req),
    .ram_grant(ram_grant), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_data(ram_data), .full(full), .empty(empty), .err(err)
`ifdef BUS_STORE_FWD_EN
    , .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    bit          full, empty, err, req, wren, sp_upd;
    logic [15:0] sp_next, ha, hd;
    bit          fhit;
    logic [15:0] fdata;
  } st_t;

  ent_t m_q[$];
  ent_t sb_q[$];
  st_t  st_q[$];

  bit          m_err, m_have, m_sp_upd;
  logic [15:0] m_addr, m_sp_next;
  logic [15:0] rd_a = 16'h0040;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the current-cycle expectation and any write the DUT issues.
  st_t  e;
  ent_t w;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("full",     16'(full),     16'(e.full));
      chk("empty",    16'(empty),    16'(e.empty));
      chk("err",      16'(err),      16'(e.err));
      chk("ram_req",  16'(ram_req),  16'(e.req));
      chk("ram_wren", 16'(ram_wren), 16'(e.wren));
      chk("sp_upd",   16'(sp_upd),   16'(e.sp_upd));
      chk("sp_next",  sp_next,       e.sp_next);
      chk("head_addr", ram_addr,     e.ha);
      chk("head_data", ram_data,     e.hd);
`ifdef BUS_STORE_FWD_EN
      chk("fwd_hit",  16'(fwd_hit),  16'(e.fhit));
      if (e.fhit) chk("fwd_data", fwd_data, e.fdata);
`endif
    end
    if (ram_wren === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL write: got unexpected write %h/%h required none", ram_addr, ram_data);
      end else begin
        w = sb_q.pop_front();
        chk("wr_addr", ram_addr, w.a);
        chk("wr_data", ram_data, w.d);
      end
    end
  end

  // One clock of stimulus; the model predicts this cycle's outputs and the next edge.
  task automatic step(input bit r, input bit a, input bit d, input bit p, input bit g,
                      input logic [15:0] b, input logic [15:0] s);
    st_t  x;
    ent_t ent;
    bit   want;
    @(posedge clk);
    #1;
    rst = r; addr_ld = a; data_ld = d; push = p; ram_grant = g; bus = b; sp = s;
`ifdef BUS_STORE_FWD_EN
    rd_addr = rd_a;
`endif
    x.full    = (m_q.size() == DEPTH);
    x.empty   = (m_q.size() == 0);
    x.req     = !x.empty;
    x.err     = m_err;
    x.wren    = !x.empty && g;
    x.sp_upd  = m_sp_upd;
    x.sp_next = m_sp_next;
    x.ha      = x.empty ? 16'h0 : m_q[0].a;
    x.hd      = x.empty ? 16'h0 : m_q[0].d;
    x.fhit    = 1'b0;
    x.fdata   = 16'h0;
    foreach (m_q[i]) if (m_q[i].a == rd_a) begin x.fhit = 1'b1; x.fdata = m_q[i].d; end
    st_q.push_back(x);
    if (x.wren) sb_q.push_back(m_q[0]);

    if (r) begin
      m_q.delete();
      m_err = 0; m_have = 0; m_sp_upd = 0; m_sp_next = 16'h0; m_addr = 16'h0;
    end else begin
      want = 0;
      m_sp_upd = 0;
      if (d && p) begin
        want = 1; ent.a = s - 16'd1; ent.d = b;
      end else if (d) begin
        if (m_have) begin want = 1; ent.a = m_addr; ent.d = b; m_have = 0; end
        else m_err = 1;
      end else if (a) begin
        m_have = 1; m_addr = b;
      end
      if (a && d) m_err = 1;
      if (x.wren) void'(m_q.pop_front());
      if (want) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(ent);
          if (p) begin m_sp_upd = 1; m_sp_next = s - 16'd1; end
        end else m_err = 1;
      end
    end
  endtask

  task automatic idle(input bit g);
    step(0, 0, 0, 0, g, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  logic [15:0] pool [6] = '{16'h0040, 16'h0041, 16'h0000, 16'h0001, 16'h0100, 16'hFFFF};

  initial begin
    rst = 1; addr_ld = 0; data_ld = 0; push = 0; ram_grant = 0; bus = '0; sp = '0;
`ifdef BUS_STORE_FWD_EN
    rd_addr = '0;
`endif
    m_err = 0; m_have = 0; m_sp_upd = 0; m_sp_next = 16'h0; m_addr = 16'h0;
    repeat (2) @(posedge clk);

    // Basic store
    idle(1);
    step(0, 1, 0, 0, 1, 16'h0040, 16'h0);
    step(0, 0, 1, 0, 1, 16'hBEEF, 16'h0);
    idle(1); idle(1);
    // Push with SP decrement, including wrap
    step(0, 0, 1, 1, 0, 16'h1234, 16'h0100);
    idle(0);
    step(0, 0, 1, 1, 0, 16'h5678, 16'h0000);
    idle(1); idle(1); idle(1);
    // Overflow then drain in push order
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 16'hA000 + 16'(i), 16'h0200 - 16'(i));
    idle(0);
    for (int i = 0; i < 6; i++) idle(1);
    // Push into a full queue while draining
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 16'hC000 + 16'(i), 16'h0300 - 16'(i));
    step(0, 0, 1, 1, 1, 16'hC0DE, 16'h02F0);
    idle(0);
    for (int i = 0; i < 5; i++) idle(1);
    // Protocol errors
    do_reset();
    step(0, 0, 1, 0, 1, 16'h9999, 16'h0);
    idle(1);
    do_reset();
    step(0, 1, 0, 0, 0, 16'h0050, 16'h0);
    step(0, 1, 1, 0, 0, 16'h7777, 16'h0);
    idle(0);
    // Reset with three queued entries
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 16'hD000 + 16'(i), 16'h0400);
    do_reset();
    idle(0);
    // Forwarding: newest match wins
    step(0, 1, 0, 0, 0, 16'h0040, 16'h0);
    step(0, 0, 1, 0, 0, 16'h1111, 16'h0);
    step(0, 1, 0, 0, 0, 16'h0040, 16'h0);
    step(0, 0, 1, 0, 0, 16'h2222, 16'h0);
    rd_a = 16'h0040; idle(0);
    rd_a = 16'h0041; idle(0);
    for (int i = 0; i < 3; i++) idle(1);

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      bit r, a, d, p, g;
      logic [15:0] b, s;
      r = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 99) < 35);
      d = ($urandom_range(0, 99) < 35);
      p = ($urandom_range(0, 1) == 1);
      g = ($urandom_range(0, 99) < 45);
      b = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 16'($urandom);
      s = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 16'($urandom);
      rd_a = pool[$urandom_range(0, 5)];
      step(r, a, d, p, g, b, s);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 16'(sb_q.size()), 16'h0);
    chk("st_drained", 16'(st_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_store_unit.md
Name: bus_store_unit

Overview:
- Write-side companion to the CPU's program/data RAM port, which the fetch path otherwise drives read-only.
- Captures a store address and a data word from the shared 16-bit bus in separate control-unit steps, or a push (pre-decremented stack pointer) in one step.
- Queues stores in a small posted-write FIFO.
- Drains one word per cycle whenever the RAM port arbiter grants the write slot, so the control unit never stalls on RAM.

Parameters:
- DATA_W, 16, bus/RAM data width
- ADDR_W, 16, RAM address width
- DEPTH, 4, posted-write queue entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- bus  in  DATA_W  shared datapath bus
- addr_ld  in  1  bus holds a store address this cycle
- data_ld  in  1  bus holds store data this cycle
- push  in  1  qualifies data_ld: address = sp-1 instead of the latched address
- sp  in  ADDR_W  current stack-pointer register value
- sp_next  out  ADDR_W  decremented stack pointer
- sp_upd  out  1  one-cycle pulse: control unit loads sp_next into the SP register
- ram_req  out  1  queue non-empty
- ram_grant  in  1  arbiter gives this unit the RAM port this cycle
- ram_wren  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address (queue head)
- ram_data  out  DATA_W  RAM write data (queue head)
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries
- err  out  1  sticky protocol/overflow error

Behaviour:
- Reset (sync, rst=1 at edge): queue empty, pointers 0, addr state NO_ADDR, err=0, sp_upd=0, sp_next=0.
- Address FSM, two states:
  - NO_ADDR --addr_ld--> ADDR_HELD (bus latched into addr_hold).
  - ADDR_HELD --data_ld&!push--> NO_ADDR (enqueue {addr_hold, bus}).
  - ADDR_HELD --addr_ld--> ADDR_HELD (new address overwrites the old).
- data_ld&!push in NO_ADDR: no enqueue, err<=1.
- addr_ld and data_ld in the same cycle: addr_ld ignored, err<=1; data_ld is processed per the rules above.
- Push (data_ld&push):
  - Enqueue {sp-1, bus}, any FSM state; FSM state unchanged.
  - sp_next<=sp-1 and sp_upd=1 on the following cycle.
  - Address arithmetic is mod 2^ADDR_W: sp=0x0000 gives 0xFFFF.
  - A dropped push (queue full) does not pulse sp_upd.
- Enqueue when full: accepted only if a dequeue occurs in the same cycle. Otherwise the entry is dropped and err<=1. A dropped store still returns the FSM to NO_ADDR.
- Drain:
  - ram_req=!empty (registered count).
  - ram_wren=ram_req&ram_grant, combinational.
  - ram_addr/ram_data show the head entry whenever non-empty, and 0 when empty.
  - The head pops at the edge ending a ram_wren cycle.
- Latency and ordering:
  - Entry enqueued at edge N is visible on ram_req in cycle N+1. With grant held high, it is written in cycle N+1.
  - Entries drain strictly FIFO.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- err clears only on rst.

Optional Feature:
- Macro: BUS_STORE_FWD_EN.
- Defined: adds input rd_addr[ADDR_W] and outputs fwd_hit[1], fwd_data[DATA_W].
  - fwd_hit=1 when any valid queued entry matches rd_addr.
  - fwd_data is the newest matching entry, combinational, same cycle.
  - Lets fetch/load logic see stores that have not yet reached RAM.
- Undefined: these ports and the match logic are absent.

Decomposition:
- Package bus_store_pkg: DATA_W/ADDR_W defaults, store_entry_t typedef {addr, data}, addr-FSM state enum.
- Sub-module store_fifo: synchronous FIFO of store_entry_t with DEPTH, push/pop/full/empty/count. When BUS_STORE_FWD_EN is defined it also exposes its entry array and valid vector for the match.

Test Plan:
- Basic store: addr_ld bus=0x0040, next cycle data_ld bus=0xBEEF, ram_grant=1 -> next cycle ram_wren=1, ram_addr=0x0040, ram_data=0xBEEF; then empty=1, err=0.
- Push/SP: sp=0x0100, data_ld&push bus=0x1234 -> entry addr 0x00FF, next cycle sp_upd=1, sp_next=0x00FF. Repeat with sp=0x0000 -> addr and sp_next 0xFFFF.
- Overflow: ram_grant=0, five pushes (DEPTH=4) -> full=1 after the 4th, 5th dropped, err=1, no sp_upd for the 5th. Then grant=1 -> four writes in push order, empty=1.
- Simultaneous: queue full, ram_grant=1, push in the same cycle -> accepted, full stays 1, err stays 0.
- Protocol and reset:
  - data_ld without prior addr_ld -> no enqueue, err=1.
  - addr_ld with data_ld in the same cycle -> err=1.
  - rst with 3 queued entries -> next cycle empty=1, ram_req=0, err=0.
- Forwarding (BUS_STORE_FWD_EN): queue 0x0040/0x1111 then 0x0040/0x2222 with grant=0, rd_addr=0x0040 -> fwd_hit=1, fwd_data=0x2222; rd_addr=0x0041 -> fwd_hit=0.
